// File: rtl/csr_ctrl.sv
// csr_ctrl: arbitrated read-modify-write front end for a single-port CSR file.
// Each accepted request walks IDLE -> READ -> WRITE -> RESP with one request in flight.
// Optional feature: define CSR_CTRL_DBG_EN to arbitrate the debug requester
// round-robin against the core; otherwise the dbg_* inputs are ignored.
module csr_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [1:0]        core_op,
  input  logic [11:0]       core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [1:0]        dbg_op,
  input  logic [11:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_src,
  output logic              csr_wen,
  output logic [11:0]       csr_addr,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic [DATA_W-1:0] csr_rdata
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        op_q;
  logic [11:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic              src_q;
  logic              grant_dbg;
  logic              accept;
  logic [1:0]        sel_op;
  logic [11:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              suppress;
  logic              read_only;
  logic [DATA_W-1:0] new_val;

`ifdef CSR_CTRL_DBG_EN
  logic prefer_dbg;

  // A lone valid requester wins; on a tie the side not served last wins
  always_comb begin
    grant_dbg = prefer_dbg;
    if (core_req_valid && !dbg_req_valid) begin
      grant_dbg = 1'b0;
    end else if (dbg_req_valid && !core_req_valid) begin
      grant_dbg = 1'b1;
    end
  end

  // Round-robin pointer: after serving one side, the other side is preferred
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prefer_dbg <= 1'b0;
    end else if (accept) begin
      prefer_dbg <= ~grant_dbg;
    end
  end

  assign accept    = (state == S_IDLE) && (grant_dbg ? dbg_req_valid : core_req_valid);
  assign sel_op    = grant_dbg ? dbg_op    : core_op;
  assign sel_addr  = grant_dbg ? dbg_addr  : core_addr;
  assign sel_wdata = grant_dbg ? dbg_wdata : core_wdata;
`else
  logic unused_dbg;

  assign unused_dbg = ^{dbg_req_valid, dbg_op, dbg_addr, dbg_wdata};
  assign grant_dbg  = 1'b0;
  assign accept     = (state == S_IDLE) && core_req_valid;
  assign sel_op     = core_op;
  assign sel_addr   = core_addr;
  assign sel_wdata  = core_wdata;
`endif

  // Latch the granted request, then capture the old CSR value during READ
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      src_q   <= 1'b0;
      old_q   <= '0;
    end else begin
      if (accept) begin
        op_q    <= sel_op;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        src_q   <= grant_dbg;
      end
      if (state == S_READ) begin
        old_q <= csr_rdata;
      end
    end
  end

  // New value from the old value and operand; reads and zero-mask set/clear never write
  always_comb begin
    suppress  = (op_q == OP_READ) || (((op_q == OP_RS) || (op_q == OP_RC)) && (wdata_q == '0));
    read_only = (addr_q[11:10] == 2'b11);
    new_val   = old_q;
    case (op_q)
      OP_RW:   new_val = wdata_q;
      OP_RS:   new_val = old_q | wdata_q;
      OP_RC:   new_val = old_q & ~wdata_q;
      default: new_val = old_q;
    endcase
  end

  // State register; reset aborts any request in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and all outputs, zero unless the current state drives them
  always_comb begin
    state_next     = state;
    core_req_ready = 1'b0;
    dbg_req_ready  = 1'b0;
    csr_wen        = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    rsp_err        = 1'b0;
    rsp_src        = 1'b0;
    case (state)
      S_IDLE: begin
        core_req_ready = !grant_dbg;
        dbg_req_ready  = grant_dbg;
        if (accept) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        csr_addr   = addr_q;
        state_next = S_WRITE;
      end
      S_WRITE: begin
        csr_addr = addr_q;
        if (!suppress && !read_only) begin
          csr_wen   = 1'b1;
          csr_wdata = new_val;
        end
        state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = old_q;
        rsp_err   = !suppress && read_only;
        rsp_src   = src_q;
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: self-checking bench for csr_ctrl with a behavioural CSR file.
// Build with CSR_CTRL_DBG_EN defined to also exercise debug arbitration.
module tb_csr_ctrl;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          core_req_valid, core_req_ready;
  logic [1:0]    core_op;
  logic [11:0]   core_addr;
  logic [DW-1:0] core_wdata;
  logic          dbg_req_valid, dbg_req_ready;
  logic [1:0]    dbg_op;
  logic [11:0]   dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_src;
  logic          csr_wen;
  logic [11:0]   csr_addr;
  logic [DW-1:0] csr_wdata;
  logic [DW-1:0] csr_rdata;

  logic [DW-1:0] env_mem [4096];
  logic [DW-1:0] ref_mem [4096];
  logic          pre_en;
  logic [11:0]   pre_addr;
  logic [DW-1:0] pre_data;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit          accepted;
    int          wen_count;
    int          wen_cycle;
    logic [11:0] wen_addr;
    logic [31:0] wen_data;
    int          rsp_cycle;
    logic [31:0] rdata;
    logic        err;
    logic        src;
    bit          addr_bad;
    bit          wdata_bad;
    bit          stable_bad;
    logic        ack_valid;
  } obs_t;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  csr_ctrl #(.DATA_W(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .core_req_valid (core_req_valid),
    .core_req_ready (core_req_ready),
    .core_op        (core_op),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .dbg_req_valid  (dbg_req_valid),
    .dbg_req_ready  (dbg_req_ready),
    .dbg_op         (dbg_op),
    .dbg_addr       (dbg_addr),
    .dbg_wdata      (dbg_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .rsp_src        (rsp_src),
    .csr_wen        (csr_wen),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata)
  );

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  assign csr_rdata = env_mem[csr_addr];

  // CSR file: DUT writes, or bench preloads while the DUT is idle
  always @(posedge clock) begin
    if (csr_wen) begin
      env_mem[csr_addr] <= csr_wdata;
    end else if (pre_en) begin
      env_mem[pre_addr] <= pre_data;
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic obs_t blank_obs();
    obs_t b;
    b.accepted = 0; b.wen_count = 0; b.wen_cycle = -1; b.wen_addr = '0; b.wen_data = '0;
    b.rsp_cycle = -1; b.rdata = '0; b.err = 1'b0; b.src = 1'b0;
    b.addr_bad = 0; b.wdata_bad = 0; b.stable_bad = 0; b.ack_valid = 1'b1;
    return b;
  endfunction

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Observe one transaction from the cycle after its accept edge up to the response handshake
  task automatic collect(input logic [11:0] addr, input int hold, input bit drop, input bit from_dbg,
                         output obs_t o);
    bit seen;
    int held;
    seen = 0;
    held = 0;
    o = blank_obs();
    o.accepted = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (drop && k == 1) begin
        if (from_dbg) dbg_req_valid = 1'b0;
        else core_req_valid = 1'b0;
      end
      if (csr_wen) begin
        o.wen_count++;
        o.wen_cycle = k;
        o.wen_addr  = csr_addr;
        o.wen_data  = csr_wdata;
      end
      if ((k == 1 || k == 2) && csr_addr !== addr) o.addr_bad = 1;
      if (k >= 3 && csr_addr !== '0) o.addr_bad = 1;
      if (k != 2 && csr_wdata !== '0) o.wdata_bad = 1;
      if (!seen) begin
        if (rsp_valid) begin
          seen = 1;
          o.rsp_cycle = k;
          o.rdata = rsp_rdata;
          o.err = rsp_err;
          o.src = rsp_src;
        end
      end else if (!rsp_valid || rsp_rdata !== o.rdata || rsp_err !== o.err || rsp_src !== o.src) begin
        o.stable_bad = 1;
      end
      if (seen) begin
        if (held >= hold) begin
          rsp_ready = 1'b1;
          @(negedge clock);
          rsp_ready = 1'b0;
          o.ack_valid = rsp_valid;
          break;
        end
        held++;
      end
    end
  endtask

  // Issue one request from one requester and observe it to completion
  task automatic applyStimulus(input bit from_dbg, input logic [1:0] op, input logic [11:0] addr,
                               input logic [31:0] wdata, input int hold, output obs_t o);
    int waited;
    bit acc;
    waited = 0;
    acc = 0;
    o = blank_obs();
    if (from_dbg) begin
      dbg_req_valid = 1'b1; dbg_op = op; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      core_req_valid = 1'b1; core_op = op; core_addr = addr; core_wdata = wdata;
    end
    while (waited < 20) begin
      #1;
      if (from_dbg ? dbg_req_ready : core_req_ready) begin
        acc = 1;
        break;
      end
      @(negedge clock);
      waited++;
    end
    if (acc) begin
      @(posedge clock);
      collect(addr, hold, 1, from_dbg, o);
    end else begin
      if (from_dbg) dbg_req_valid = 1'b0;
      else core_req_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  // Reference model: expected effect of a request from the read-modify-write rules
  task automatic checkTxn(input string tag, input bit from_dbg, input logic [1:0] op,
                          input logic [11:0] addr, input logic [31:0] wdata, input obs_t o);
    logic [31:0] old, newv;
    bit quiet, err, writes;
    old = ref_mem[addr];
    quiet = (op == 2'b00) || (op != 2'b01 && wdata == 32'd0);
    if (op == 2'b01) newv = wdata;
    else if (op == 2'b10) newv = old | wdata;
    else newv = old & ~wdata;
    err = !quiet && (addr[11:10] == 2'b11);
    writes = !quiet && !err;
    checkOutput({tag, ".accepted"},  64'(o.accepted),   64'd1);
    checkOutput({tag, ".wen_count"}, 64'(o.wen_count),  writes ? 64'd1 : 64'd0);
    checkOutput({tag, ".wen_cycle"}, 64'(o.wen_cycle),  writes ? 64'd2 : 64'(-1));
    checkOutput({tag, ".wen_data"},  64'(o.wen_data),   writes ? 64'(newv) : 64'd0);
    checkOutput({tag, ".wen_addr"},  64'(o.wen_addr),   writes ? 64'(addr) : 64'd0);
    checkOutput({tag, ".rsp_cycle"}, 64'(o.rsp_cycle),  64'd3);
    checkOutput({tag, ".rdata"},     64'(o.rdata),      64'(old));
    checkOutput({tag, ".err"},       64'(o.err),        64'(err));
    checkOutput({tag, ".src"},       64'(o.src),        64'(from_dbg));
    checkOutput({tag, ".addr_bus"},  64'(o.addr_bad),   64'd0);
    checkOutput({tag, ".wdata_bus"}, 64'(o.wdata_bad),  64'd0);
    checkOutput({tag, ".stable"},    64'(o.stable_bad), 64'd0);
    checkOutput({tag, ".ack_idle"},  64'(o.ack_valid),  64'd0);
    if (writes) ref_mem[addr] = newv;
  endtask

  vec_t        vecs [10];
  obs_t        o;
  logic [11:0] pool [8];
  bit          exp_dbg, got_dbg, granted, quiet_bad, from;
  int          w;
  logic [1:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;

  initial begin
    reset = 1'b1;
    core_req_valid = 1'b0; core_op = '0; core_addr = '0; core_wdata = '0;
    dbg_req_valid = 1'b0; dbg_op = '0; dbg_addr = '0; dbg_wdata = '0;
    rsp_ready = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    vecs[0] = '{2'b10, 12'hB00, 32'h0000_00F0, 32'h0000_0F0F, 1'b1, 32'h0000_0FFF, 1'b0};
    vecs[1] = '{2'b11, 12'hB80, 32'hFFFF_0000, 32'h1234_5678, 1'b1, 32'h0000_5678, 1'b0};
    vecs[2] = '{2'b01, 12'hF11, 32'h0000_0001, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{2'b10, 12'hF12, 32'h0000_0000, 32'h0BAD_BEEF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{2'b01, 12'h300, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{2'b00, 12'hC00, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6] = '{2'b11, 12'h341, 32'h0000_0000, 32'h0000_00FF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'b11, 12'hFFF, 32'h0000_0010, 32'h0000_00FF, 1'b0, 32'h0000_0000, 1'b1};
    vecs[8] = '{2'b00, 12'h7FF, 32'h0000_0000, 32'h600D_CAFE, 1'b0, 32'h0000_0000, 1'b0};
    vecs[9] = '{2'b10, 12'h001, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0001, 1'b0};

    @(negedge clock);
    @(negedge clock);
    checkOutput("reset.core_ready", 64'(core_req_ready), 64'd1);
    checkOutput("reset.dbg_ready",  64'(dbg_req_ready),  64'd0);
    checkOutput("reset.rsp_valid",  64'(rsp_valid),      64'd0);
    checkOutput("reset.rsp_rdata",  64'(rsp_rdata),      64'd0);
    checkOutput("reset.rsp_err",    64'(rsp_err),        64'd0);
    checkOutput("reset.rsp_src",    64'(rsp_src),        64'd0);
    checkOutput("reset.csr_wen",    64'(csr_wen),        64'd0);
    checkOutput("reset.csr_addr",   64'(csr_addr),       64'd0);
    checkOutput("reset.csr_wdata",  64'(csr_wdata),      64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].addr, vecs[i].pre);
      applyStimulus(1'b0, vecs[i].op, vecs[i].addr, vecs[i].wdata, 0, o);
      checkOutput($sformatf("vec%0d.accepted", i),  64'(o.accepted), 64'd1);
      checkOutput($sformatf("vec%0d.wen_count", i), 64'(o.wen_count), vecs[i].exp_wen ? 64'd1 : 64'd0);
      checkOutput($sformatf("vec%0d.wen_cycle", i), 64'(o.wen_cycle), vecs[i].exp_wen ? 64'd2 : 64'(-1));
      checkOutput($sformatf("vec%0d.wen_data", i),  64'(o.wen_data), 64'(vecs[i].exp_wdata));
      checkOutput($sformatf("vec%0d.rsp_cycle", i), 64'(o.rsp_cycle), 64'd3);
      checkOutput($sformatf("vec%0d.rdata", i),     64'(o.rdata), 64'(vecs[i].pre));
      checkOutput($sformatf("vec%0d.err", i),       64'(o.err), 64'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d.src", i),       64'(o.src), 64'd0);
      checkOutput($sformatf("vec%0d.addr_bus", i),  64'(o.addr_bad), 64'd0);
      checkOutput($sformatf("vec%0d.ack_idle", i),  64'(o.ack_valid), 64'd0);
    end

    // Both requesters valid for three transactions; first response held for 5 cycles
    doReset();
    preload(12'h305, 32'h0305_AAAA);
    preload(12'h341, 32'h0341_BBBB);
    core_op = 2'b00; core_addr = 12'h305; core_wdata = '0;
    dbg_op  = 2'b00; dbg_addr  = 12'h341; dbg_wdata  = '0;
    core_req_valid = 1'b1;
    dbg_req_valid  = 1'b1;
    for (int t = 0; t < 3; t++) begin
`ifdef CSR_CTRL_DBG_EN
      exp_dbg = (t == 1);
`else
      exp_dbg = 1'b0;
`endif
      granted = 0;
      w = 0;
      while (w < 20) begin
        #1;
        if (core_req_ready || dbg_req_ready) begin
          granted = 1;
          break;
        end
        @(negedge clock);
        w++;
      end
      got_dbg = dbg_req_ready;
      checkOutput($sformatf("arb%0d.granted", t),   64'(granted), 64'd1);
      checkOutput($sformatf("arb%0d.grant_dbg", t), 64'(got_dbg), 64'(exp_dbg));
      checkOutput($sformatf("arb%0d.exclusive", t), 64'(core_req_ready & dbg_req_ready), 64'd0);
      @(posedge clock);
      collect(exp_dbg ? 12'h341 : 12'h305, (t == 0) ? 5 : 0, 0, 0, o);
      checkOutput($sformatf("arb%0d.rsp_src", t),   64'(o.src), 64'(exp_dbg));
      checkOutput($sformatf("arb%0d.rdata", t),     64'(o.rdata), exp_dbg ? 64'h0341_BBBB : 64'h0305_AAAA);
      checkOutput($sformatf("arb%0d.rsp_cycle", t), 64'(o.rsp_cycle), 64'd3);
      checkOutput($sformatf("arb%0d.stable", t),    64'(o.stable_bad), 64'd0);
    end
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    @(negedge clock);

    // Reset asserted in the WRITE cycle of an RW to 0xB00 aborts the request
    doReset();
    preload(12'hB00, 32'hAAAA_5555);
    core_req_valid = 1'b1; core_op = 2'b01; core_addr = 12'hB00; core_wdata = 32'h1234_5678;
    #1;
    checkOutput("rst.accept_ready", 64'(core_req_ready), 64'd1);
    @(negedge clock);
    core_req_valid = 1'b0;
    @(negedge clock);
    checkOutput("rst.write_state_wen", 64'(csr_wen), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst.wen_abort",   64'(csr_wen),   64'd0);
    checkOutput("rst.rsp_abort",   64'(rsp_valid), 64'd0);
    checkOutput("rst.addr_abort",  64'(csr_addr),  64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst.core_ready_after", 64'(core_req_ready), 64'd1);
    quiet_bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (csr_wen || rsp_valid) quiet_bad = 1;
    end
    checkOutput("rst.quiet_after", 64'(quiet_bad), 64'd0);
    applyStimulus(1'b0, 2'b00, 12'hB00, 32'd0, 0, o);
    checkOutput("rst.mem_untouched", 64'(o.rdata), 64'hAAAA_5555);
    checkOutput("rst.read_no_wen",   64'(o.wen_count), 64'd0);

    // Randomized requests checked against the reference model
    pool[0] = 12'h000; pool[1] = 12'h001; pool[2] = 12'h305; pool[3] = 12'h341;
    pool[4] = 12'hB00; pool[5] = 12'hB80; pool[6] = 12'hC00; pool[7] = 12'hF11;
    for (int p = 0; p < 8; p++) begin
      preload(pool[p], 32'($urandom));
    end
`ifndef CSR_CTRL_DBG_EN
    dbg_req_valid = 1'b1; dbg_op = 2'b01; dbg_addr = pool[2]; dbg_wdata = 32'($urandom);
`endif
    for (int n = 0; n < 40; n++) begin
`ifdef CSR_CTRL_DBG_EN
      from = 1'($urandom_range(0, 1));
`else
      from = 1'b0;
`endif
      r_op    = 2'($urandom_range(0, 3));
      r_addr  = pool[$urandom_range(0, 7)];
      r_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      applyStimulus(from, r_op, r_addr, r_wdata, int'($urandom_range(0, 2)), o);
      checkTxn($sformatf("rand%0d", n), from, r_op, r_addr, r_wdata, o);
`ifndef CSR_CTRL_DBG_EN
      checkOutput($sformatf("rand%0d.dbg_ready_tied", n), 64'(dbg_req_ready), 64'd0);
`endif
    end
    dbg_req_valid = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
